// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: start pulse with operands in,
// busy/done status and held sum/carry-out back.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first with a registered carry; done strobes WIDTH+1 edges after accept.
// No backpressure: start is only honoured in IDLE and is dropped while RUN/DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int             CW   = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;
    logic [CW-1:0]    cnt_q;

    always_comb begin
        bit_s     = opa_q[0] ^ opb_q[0] ^ carry_q;
        // Two half adders plus an OR: generate | (carry & propagate).
        carry_nxt = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
        psum_nxt  = (psum_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        last_bit  = (cnt_q == LAST);

        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    psum_q  <= psum_nxt;
                    carry_q <= carry_nxt;
                    cnt_q   <= cnt_q + CW'(1);
                    // Outputs only move on completion so partial sums never leak out.
                    if (last_bit) begin
                        sum_q  <= psum_nxt;
                        cout_q <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial unsigned adder built around a one-bit sum/carry stage with a registered carry. It is the sequential stage downstream of the half-adder cell. It accepts two WIDTH-bit operands on a start pulse and processes them LSB-first, one bit per clock. It then presents a WIDTH-bit sum plus carry-out with a one-cycle done strobe. Intended for area-cheap arithmetic in the clock design, such as time-value increment/adjust paths, where latency is irrelevant.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle strobe: sum/cout valid and newly updated
sum  output  WIDTH  result a+b mod 2^WIDTH; holds last result
cout  output  1  carry out of bit WIDTH-1; holds last result

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - rst has priority over every other input, including start on the same edge.
- States: IDLE, RUN, DONE. Encoding is free. busy=(state==RUN); done=(state==DONE); both are registered, with no combinational path from inputs.
- IDLE:
  - start=1 at an edge: capture a and b into operand shift regs, carry=0, bit counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Form s = opa[0]^opb[0]^carry and carry_next = majority(opa[0], opb[0], carry). This is equivalent to two half adders plus an OR.
  - Shift opa and opb right by 1.
  - Shift the partial-sum register right, inserting s at the MSB.
  - Increment the counter.
  - On the edge where counter==WIDTH-1 (the last bit), load the sum output with the completed partial sum, including this bit. Load cout with carry_next. Go to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE unconditionally.
  - start is ignored here.
- start asserted in RUN or DONE is ignored: no queuing, no effect on the in-flight result.
- Latency: call the start-accept edge E0. done is high in the cycle following edge E0+WIDTH, and deasserts after edge E0+WIDTH+1.
- Throughput: the next start can be accepted at E0+WIDTH+2 at the earliest.
- Output stability:
  - sum and cout change only on the RUN-to-DONE edge or on reset.
  - Partial results are never visible on sum/cout.
  - Values persist through IDLE until the next completion.
- Operands a/b may change freely after the accept edge; the result uses the captured values.
- Reset mid-operation (RUN or DONE): abort; the reset values above apply; done never asserts for the aborted operation.
- Counter width: ceil(log2(WIDTH+1)) bits, minimum 1. No overflow is possible.
- WIDTH=1: a single RUN cycle; result equals the half-adder truth table (sum=a^b, cout=a&b).

Test Plan:
1. WIDTH=8, rst held 2 cycles, then start with a=0x00, b=0x00 -> busy high 8 cycles; done pulses 1 cycle at E0+8; sum=0x00, cout=0; sum/cout are 0 throughout reset.
2. WIDTH=8: a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A -> sum=0xFF, cout=0. Then a=0x80, b=0x80 -> sum=0x00, cout=1. Each done is exactly one cycle and sum is unchanged between dones.
3. WIDTH=8: start a=0x12, b=0x34; during RUN pulse start with a=0xFF, b=0xFF, and change a/b -> result sum=0x46, cout=0; no extra done; the next start is accepted only after returning to IDLE.
4. WIDTH=8: start a=0x7F, b=0x7F; assert rst on the 4th RUN cycle -> busy=0, sum=0, cout=0 on the next cycle; no done. A subsequent start with a=0x7F, b=0x7F gives sum=0xFE, cout=0.
5. WIDTH=1: all four (a,b) pairs (0,0), (1,0), (0,1), (1,1) -> (sum,cout)=(0,0), (1,0), (1,0), (0,1); done at E0+1.
6. WIDTH=8: random 1000 operand pairs back-to-back at maximum rate -> each result matches {cout,sum}=a+b; done spacing is exactly 10 cycles.
